// File: rtl/cdrom_dma_pkg.sv
// Shared types and constants for the CD-ROM data FIFO to DMA channel 3 packer.
//   DMA_STATE_t    : block state machine encoding
//   BYTES_PER_WORD : bytes packed into one DMA word
//   BFRD_BIT       : position of the "want data" bit in the host request register
package cdrom_dma_pkg;

    typedef enum logic [1:0] {
        IDLE_P,
        FILL_P,
        PRESENT_P,
        DONE_P
    } DMA_STATE_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BFRD_BIT       = 7;

endpackage

// File: rtl/cdrom_byte_packer.sv
// Four-lane little-endian byte packer. Each load writes din into the current lane
// and advances the lane index; clear empties the register and rewinds the lane.
//   clk, rst : clock, synchronous active-high reset
//   load     : write din into the current lane
//   clear    : discard contents, lane back to 0 (wins over load)
//   din      : incoming byte
//   word     : packed word, lane 0 in bits [7:0]
//   full     : current lane is the last one, so the next load completes the word
module cdrom_byte_packer
    import cdrom_dma_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        full
);

    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    logic [BYTES_PER_WORD-1:0][7:0] word_q;
    logic [1:0]                     lane_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word_q <= '0;
            lane_q <= '0;
        end else if (load) begin
            word_q[lane_q] <= din;
            lane_q         <= lane_q + 2'd1;
        end
    end

    assign word = word_q;
    assign full = (lane_q == LAST_LANE);

endmodule

// File: rtl/cdrom_dma_packer.sv
// Drains the CD-ROM data FIFO, packs bytes little-endian into 32-bit words and
// hands them to DMA channel 3 over valid/ready, one block of dma_words at a time.
// Transfers only while want_data (BFRD) is set; a block aborts on FIFO starvation
// or when want_data is withdrawn.
//   clk, rst                 : clock, synchronous active-high reset
//   want_data                : host BFRD request bit
//   fifo_data, fifo_empty    : show-ahead FIFO head byte and empty flag
//   fifo_re                  : pop strobe
//   dma_start, dma_words     : block request and its length in words
//   dma_busy                 : block in progress
//   dma_data, dma_valid      : packed word offered to DMA
//   dma_ready                : DMA accepts the word
//   dma_done, dma_abort      : end-of-block pulse, early-end qualifier
// Optional (macro CDROM_DMA_STATS_EN):
//   stat_words               : saturating count of accepted words
//   stat_stalls              : saturating count of FILL cycles with the FIFO empty
module cdrom_dma_packer
    import cdrom_dma_pkg::*;
#(
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             want_data,
    input  logic [7:0]       fifo_data,
    input  logic             fifo_empty,
    output logic             fifo_re,
    input  logic             dma_start,
    input  logic [CNT_W-1:0] dma_words,
    output logic             dma_busy,
    output logic [31:0]      dma_data,
    output logic             dma_valid,
    input  logic             dma_ready,
    output logic             dma_done,
    output logic             dma_abort
`ifdef CDROM_DMA_STATS_EN
    ,
    output logic [31:0]      stat_words,
    output logic [15:0]      stat_stalls
`endif
);

    localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    DMA_STATE_t       state_q, state_d;
    logic [CNT_W-1:0] remaining_q;
    logic [TMO_W-1:0] tmo_q, tmo_inc;
    logic             abort_q;

    logic             start_ok, fill_abort, word_accept, last_word;
    logic             pk_clear, pk_full;
    logic [31:0]      pk_word;

    always_comb begin
        start_ok    = (state_q == IDLE_P) && dma_start && want_data && (dma_words != '0);
        tmo_inc     = tmo_q + TMO_W'(1);
        fill_abort  = (state_q == FILL_P) &&
                      (!want_data || (fifo_empty && (tmo_inc == TMO_LAST)));
        word_accept = (state_q == PRESENT_P) && dma_ready;
        last_word   = (remaining_q == CNT_W'(1));
        // Any block end or accepted word empties the packer; abort drops partial bytes.
        pk_clear    = start_ok || fill_abort || word_accept;
    end

    cdrom_byte_packer u_packer (
        .clk   (clk),
        .rst   (rst),
        .load  (fifo_re),
        .clear (pk_clear),
        .din   (fifo_data),
        .word  (pk_word),
        .full  (pk_full)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE_P;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE_P: begin
                if (start_ok) state_d = FILL_P;
            end
            FILL_P: begin
                if (fill_abort) begin
                    state_d = DONE_P;
                end else if (!fifo_empty && pk_full) begin
                    state_d = PRESENT_P;
                end
            end
            PRESENT_P: begin
                if (dma_ready) begin
                    // A presented word always completes even if want_data has dropped.
                    state_d = (last_word || !want_data) ? DONE_P : FILL_P;
                end
            end
            DONE_P:  state_d = IDLE_P;
            default: state_d = IDLE_P;
        endcase
    end

    // Outputs
    always_comb begin
        fifo_re   = (state_q == FILL_P) && want_data && !fifo_empty;
        dma_busy  = (state_q == FILL_P) || (state_q == PRESENT_P);
        dma_valid = (state_q == PRESENT_P);
        dma_data  = pk_word;
        dma_done  = (state_q == DONE_P);
        dma_abort = (state_q == DONE_P) && abort_q;
    end

    // Block bookkeeping: remaining words, starvation timer, abort flag
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_q <= '0;
            tmo_q       <= '0;
            abort_q     <= 1'b0;
        end else begin
            if (start_ok) begin
                remaining_q <= dma_words;
                tmo_q       <= '0;
                abort_q     <= 1'b0;
            end
            if (state_q == FILL_P) begin
                if (fill_abort) begin
                    abort_q <= 1'b1;
                    tmo_q   <= '0;
                end else if (!fifo_empty) begin
                    tmo_q <= '0;
                end else begin
                    tmo_q <= tmo_inc;
                end
            end
            if (word_accept) begin
                remaining_q <= remaining_q - CNT_W'(1);
                if (!last_word && !want_data) abort_q <= 1'b1;
            end
        end
    end

`ifdef CDROM_DMA_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_words  <= '0;
            stat_stalls <= '0;
        end else begin
            if (word_accept && (stat_words != '1)) begin
                stat_words <= stat_words + 32'd1;
            end
            if ((state_q == FILL_P) && fifo_empty && (stat_stalls != '1)) begin
                stat_stalls <= stat_stalls + 16'd1;
            end
        end
    end
`endif

endmodule
